// File: rtl/bpu_ghr_ckpt.sv
`default_nettype none
// ============================================================================
//  Module      : bpu_ghr_ckpt
//  Description : Speculative global-history register with an in-order
//                checkpoint buffer for misprediction / flush repair, plus
//                the committed (architectural) history.
//  Revision    : 1.0  initial release
// ============================================================================
module bpu_ghr_ckpt #(
  parameter int HIST_LEN   = 64,
  parameter int CKPT_DEPTH = 8,
  parameter int CKPT_ID_W  = $clog2(CKPT_DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 pred_valid_i,
  input  logic                 pred_taken_i,
  output logic                 pred_ready_o,
  output logic [CKPT_ID_W-1:0] pred_ckpt_id_o,
  output logic [HIST_LEN-1:0]  ghr_o,
  input  logic                 redirect_valid_i,
  input  logic [CKPT_ID_W-1:0] redirect_ckpt_id_i,
  input  logic                 redirect_taken_i,
  input  logic                 commit_valid_i,
  input  logic                 commit_taken_i,
  input  logic                 flush_i,
  output logic [HIST_LEN-1:0]  arch_ghr_o,
  output logic [CKPT_ID_W-1:0] ckpt_count_o
);

  localparam int IDX_W = CKPT_ID_W - 1;
  localparam logic [CKPT_ID_W-1:0] PTR_ONE = CKPT_ID_W'(1);

  logic [HIST_LEN-1:0]  spec_ghr;
  logic [HIST_LEN-1:0]  arch_ghr;
  logic [HIST_LEN-1:0]  spec_ghr_nxt;
  logic [HIST_LEN-1:0]  arch_ghr_nxt;
  logic [CKPT_ID_W-1:0] head;
  logic [CKPT_ID_W-1:0] tail;
  logic [CKPT_ID_W-1:0] head_nxt;
  logic [CKPT_ID_W-1:0] tail_nxt;
  logic [HIST_LEN-1:0]  ckpt_mem [CKPT_DEPTH];
  logic [HIST_LEN-1:0]  redirect_hist;

  logic full;
  logic empty;
  logic accept;
  logic commit_ok;

  // Same index with opposite wrap bit means the buffer has lapped the head.
  assign full      = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[IDX_W] != tail[IDX_W]);
  assign empty     = (head == tail);
  assign accept    = pred_valid_i && pred_ready_o;
  assign commit_ok = commit_valid_i && !empty;

  assign redirect_hist = ckpt_mem[redirect_ckpt_id_i[IDX_W-1:0]];

  // Next-state: commit is independent; flush > redirect > accept for the spec side.
  always_comb begin
    arch_ghr_nxt = arch_ghr;
    head_nxt     = head;
    if (commit_ok) begin
      arch_ghr_nxt = {arch_ghr[HIST_LEN-2:0], commit_taken_i};
      head_nxt     = head + PTR_ONE;
    end

    spec_ghr_nxt = spec_ghr;
    tail_nxt     = tail;
    if (flush_i) begin
      // Flush restarts from committed history, including a same-cycle commit.
      spec_ghr_nxt = arch_ghr_nxt;
      tail_nxt     = head_nxt;
    end else if (redirect_valid_i) begin
      // Mispredicted branch keeps its slot; everything younger is dropped.
      spec_ghr_nxt = {redirect_hist[HIST_LEN-2:0], redirect_taken_i};
      tail_nxt     = redirect_ckpt_id_i + PTR_ONE;
    end else if (accept) begin
      spec_ghr_nxt = {spec_ghr[HIST_LEN-2:0], pred_taken_i};
      tail_nxt     = tail + PTR_ONE;
    end
  end

  // History and pointer registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      spec_ghr <= '0;
      arch_ghr <= '0;
      head     <= '0;
      tail     <= '0;
    end else begin
      spec_ghr <= spec_ghr_nxt;
      arch_ghr <= arch_ghr_nxt;
      head     <= head_nxt;
      tail     <= tail_nxt;
    end
  end

  // Checkpoint RAM holds the history seen before each accepted branch; no reset needed.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      ckpt_mem[tail[IDX_W-1:0]] <= spec_ghr;
    end
  end

  assign pred_ready_o   = !full && !redirect_valid_i && !flush_i;
  assign pred_ckpt_id_o = tail;
  assign ghr_o          = spec_ghr;
  assign arch_ghr_o     = arch_ghr;
  assign ckpt_count_o   = tail - head;

endmodule
`default_nettype wire

// File: tb/tb_bpu_ghr_ckpt.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bpu_ghr_ckpt
//  Description : Scoreboard bench for bpu_ghr_ckpt. A queue-based model of
//                the in-flight branches produces expected outputs; a
//                negedge monitor pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bpu_ghr_ckpt;

  localparam int HIST_LEN   = 64;
  localparam int CKPT_DEPTH = 8;
  localparam int CKPT_ID_W  = 4;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 pred_valid = 1'b0;
  logic                 pred_taken = 1'b0;
  logic                 pred_ready;
  logic [CKPT_ID_W-1:0] pred_ckpt_id;
  logic [HIST_LEN-1:0]  ghr;
  logic                 redirect_valid = 1'b0;
  logic [CKPT_ID_W-1:0] redirect_id = '0;
  logic                 redirect_taken = 1'b0;
  logic                 commit_valid = 1'b0;
  logic                 commit_taken = 1'b0;
  logic                 flush = 1'b0;
  logic [HIST_LEN-1:0]  arch_ghr;
  logic [CKPT_ID_W-1:0] ckpt_count;

  bpu_ghr_ckpt #(
    .HIST_LEN   (HIST_LEN),
    .CKPT_DEPTH (CKPT_DEPTH),
    .CKPT_ID_W  (CKPT_ID_W)
  ) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .pred_valid_i       (pred_valid),
    .pred_taken_i       (pred_taken),
    .pred_ready_o       (pred_ready),
    .pred_ckpt_id_o     (pred_ckpt_id),
    .ghr_o              (ghr),
    .redirect_valid_i   (redirect_valid),
    .redirect_ckpt_id_i (redirect_id),
    .redirect_taken_i   (redirect_taken),
    .commit_valid_i     (commit_valid),
    .commit_taken_i     (commit_taken),
    .flush_i            (flush),
    .arch_ghr_o         (arch_ghr),
    .ckpt_count_o       (ckpt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [HIST_LEN-1:0]  ghr;
    logic [HIST_LEN-1:0]  arch;
    logic [CKPT_ID_W-1:0] cnt;
    logic [CKPT_ID_W-1:0] id;
    logic                 rdy;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // Reference model: list of histories of in-flight branches, oldest first.
  logic [HIST_LEN-1:0] m_spec;
  logic [HIST_LEN-1:0] m_arch;
  logic [HIST_LEN-1:0] m_q[$];
  int                  m_head;

  task automatic chk(input string nm, input logic [HIST_LEN-1:0] act, input logic [HIST_LEN-1:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("ghr_o", ghr, e.ghr);
      chk("arch_ghr_o", arch_ghr, e.arch);
      chk("ckpt_count_o", 64'(ckpt_count), 64'(e.cnt));
      chk("pred_ckpt_id_o", 64'(pred_ckpt_id), 64'(e.id));
      chk("pred_ready_o", 64'(pred_ready), 64'(e.rdy));
    end
  end

  task automatic idle();
    pred_valid = 0; pred_taken = 0; redirect_valid = 0; redirect_id = '0;
    redirect_taken = 0; commit_valid = 0; commit_taken = 0; flush = 0;
  endtask

  // One clock cycle of stimulus: drive, predict, advance the model, wait for the edge.
  task automatic step(input logic pv, input logic pt, input logic rv, input logic [3:0] rid,
                      input logic rt, input logic cv, input logic ct, input logic fl);
    exp_t e;
    int   size0;
    int   off;
    logic m_full;
    pred_valid = pv; pred_taken = pt; redirect_valid = rv; redirect_id = rid;
    redirect_taken = rt; commit_valid = cv; commit_taken = ct; flush = fl;
    size0  = m_q.size();
    m_full = (size0 == CKPT_DEPTH);
    e.ghr  = m_spec;
    e.arch = m_arch;
    e.cnt  = 4'(size0);
    e.id   = 4'((m_head + size0) % 16);
    e.rdy  = !m_full && !rv && !fl;
    sbq.push_back(e);
    off = (int'(rid) - m_head + 16) % 16;
    if (!fl && rv) begin
      if (off >= size0) begin
        total++; bad++;
        $display("FAIL redirect_range id=%0d head=%0d live=%0d", rid, m_head, size0);
      end else begin
        m_spec = {m_q[off][HIST_LEN-2:0], rt};
        while (m_q.size() > off + 1) void'(m_q.pop_back());
      end
    end else if (!fl && pv && !m_full) begin
      m_q.push_back(m_spec);
      m_spec = {m_spec[HIST_LEN-2:0], pt};
    end
    if (cv) begin
      if (size0 > 0) begin
        void'(m_q.pop_front());
        m_head = (m_head + 1) % 16;
        m_arch = {m_arch[HIST_LEN-2:0], ct};
      end else begin
        total++; bad++;
        $display("FAIL commit_empty head=%0d", m_head);
      end
    end
    if (fl) begin
      m_q.delete();
      m_spec = m_arch;
    end
    @(posedge clk);
    #2;
    idle();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    idle();
    rstn = 0;
    #1;
    chk("rst_ghr", ghr, '0);
    chk("rst_arch", arch_ghr, '0);
    chk("rst_count", 64'(ckpt_count), 64'd0);
    chk("rst_id", 64'(pred_ckpt_id), 64'd0);
    chk("rst_ready", 64'(pred_ready), 64'd1);
    m_spec = '0; m_arch = '0; m_q.delete(); m_head = 0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] rid;
    m_spec = '0; m_arch = '0; m_head = 0;
    #3;
    do_reset();

    // Three accepts 1,0,1.
    step(1,1,0,0,0,0,0,0); step(1,0,0,0,0,0,0,0); step(1,1,0,0,0,0,0,0);
    chk("dir1_ghr", ghr, 64'h5);
    chk("dir1_count", 64'(ckpt_count), 64'd3);

    // Fill to full, extra request ignored, commit reopens.
    do_reset();
    for (int i = 0; i < 8; i++) step(1,1,0,0,0,0,0,0);
    chk("full_ready", 64'(pred_ready), 64'd0);
    step(1,1,0,0,0,0,0,0);
    chk("full_ghr", ghr, 64'hFF);
    chk("full_count", 64'(ckpt_count), 64'd8);
    step(0,0,0,0,0,1,1,0);
    chk("full_ready_back", 64'(pred_ready), 64'd1);

    // Redirect into the middle of the buffer.
    do_reset();
    for (int i = 0; i < 5; i++) step(1,1,0,0,0,0,0,0);
    step(0,0,1,4'd2,0,0,0,0);
    chk("redir_ghr", ghr, 64'h6);
    chk("redir_count", 64'(ckpt_count), 64'd3);
    chk("redir_next_id", 64'(pred_ckpt_id), 64'd3);
    step(1,0,0,0,0,0,0,0);
    // Redirect wins over a simultaneous prediction.
    step(1,1,1,4'd1,1,0,0,0);
    chk("redir_pv_count", 64'(ckpt_count), 64'd2);
    chk("redir_pv_id", 64'(pred_ckpt_id), 64'd2);

    // Flush together with a commit.
    do_reset();
    for (int i = 0; i < 4; i++) step(1,1,0,0,0,0,0,0);
    step(0,0,0,0,0,1,1,0); step(0,0,0,0,0,1,0,0);
    step(0,0,0,0,0,1,1,1);
    chk("flush_arch", arch_ghr, 64'h5);
    chk("flush_ghr", ghr, 64'h5);
    chk("flush_count", 64'(ckpt_count), 64'd0);

    // Wrap-around with steady occupancy of one.
    do_reset();
    step(1,1,0,0,0,0,0,0);
    for (int i = 0; i < 20; i++) step(1, 1'(i), 0,0,0, 1, 1'(i+1), 0);
    chk("wrap_count", 64'(ckpt_count), 64'd1);
    chk("wrap_id", 64'(pred_ckpt_id), 64'd5);
    step(0,0,1,4'd4,1,0,0,0);
    chk("wrap_redir_count", 64'(ckpt_count), 64'd1);

    // Randomized traffic with one asynchronous reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      logic pv, pt, rv, rt, cv, ct, fl;
      if (c == 1500) begin
        #1;
        do_reset();
      end
      n  = m_q.size();
      pv = ($urandom % 4) != 0;
      pt = 1'($urandom);
      cv = (n > 0) && (($urandom % 3) == 0);
      ct = 1'($urandom);
      rv = (n > 0) && (($urandom % 12) == 0);
      rt = 1'($urandom);
      rid = (n > 0) ? 4'((m_head + int'($urandom % n)) % 16) : 4'd0;
      fl = (($urandom % 40) == 0);
      step(pv, pt, rv, rid, rt, cv, ct, fl);
    end

    @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
